// File: rtl/approx_seg_adder_pkg.sv
// Shared types and constants for the segmented approximate adder.
package approx_seg_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    CORR = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic MODE_APPROX = 1'b0;
  localparam logic MODE_EXACT  = 1'b1;

endpackage

// File: rtl/approx_seg_adder_seg_add.sv
// One SEG-bit segment of the adder chain: a + b + cin with carry-out.
module seg_add #(
  parameter int unsigned SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout
);

  logic [SEG:0] full;

  assign full = {1'b0, a} + {1'b0, b} + (SEG+1)'(cin);
  assign sum  = full[SEG-1:0];
  assign cout = full[SEG];

endmodule

// File: rtl/approx_seg_adder.sv
// Segmented adder with speculative inter-segment carries, error detection
// and an optional correction pass that reuses the same segment chain.
module approx_seg_adder
  import approx_seg_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SEG   = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             err,
  output logic             corr,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned NSEG = WIDTH / SEG;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic             mode_q;
  logic [WIDTH-1:0] seg_sum;
  logic [NSEG-1:0]  mism;
  logic             top_cout;
  logic             err_c;
  logic             load_c;
  logic             inc_c;

  // In EVAL each segment takes the speculative carry; in CORR the same chain
  // ripples the true carries, giving the exact sum. The first segment whose
  // speculative carry-in disagrees with its neighbour's carry-out is exactly
  // the first wrong speculation, so OR-ing those disagreements yields err.
  for (genvar i = 0; i < NSEG; i++) begin : gen_seg
    logic           cin;
    logic           cout;
    logic [SEG-1:0] s;

    if (i == 0) begin : g_first
      assign cin     = 1'b0;
      assign mism[i] = 1'b0;
    end else begin : g_rest
      logic spec;
      assign spec    = a_q[i*SEG-1] & b_q[i*SEG-1];
      assign cin     = (state_q == CORR) ? gen_seg[i-1].cout : spec;
      assign mism[i] = spec ^ gen_seg[i-1].cout;
    end

    seg_add #(.SEG(SEG)) u_seg (
      .a    (a_q[i*SEG +: SEG]),
      .b    (b_q[i*SEG +: SEG]),
      .cin  (cin),
      .sum  (s),
      .cout (cout)
    );

    assign seg_sum[i*SEG +: SEG] = s;
  end

  assign top_cout = gen_seg[NSEG-1].cout;
  assign err_c    = |mism;

  // Next-state and load/increment strobes
  always_comb begin
    state_d = state_q;
    load_c  = 1'b0;
    inc_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) state_d = EVAL;
      end
      EVAL: begin
        inc_c = err_c;
        if (mode_q == MODE_EXACT && err_c) begin
          state_d = CORR;
        end else begin
          state_d = DONE;
          load_c  = 1'b1;
        end
      end
      CORR: begin
        state_d = DONE;
        load_c  = 1'b1;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, operand capture and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      mode_q    <= MODE_APPROX;
      sum       <= '0;
      err       <= 1'b0;
      corr      <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      if (state_q == IDLE && in_valid) begin
        a_q    <= a;
        b_q    <= b;
        mode_q <= mode;
      end
      if (load_c) begin
        sum  <= {top_cout, seg_sum};
        err  <= (state_q == CORR) | err_c;
        corr <= (state_q == CORR);
      end
      if (inc_c && err_cnt != {CNT_W{1'b1}}) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end

endmodule
